// File: rtl/pgm_pkg.sv
// pgm_pkg
// Shared types and constants for the program-RAM arbitration slice.
//   PGM_ADDR_W     : program RAM address width (128 entries)
//   PGM_DATA_W     : program RAM word width
//   pgm_wr_entry_t : one posted write (address + data)
//   pgm_grant_e    : which requester owns the RAM port in the current cycle
//   pgm_ret_e      : read-return tracking state
package pgm_pkg;

   localparam int PGM_ADDR_W = 7;
   localparam int PGM_DATA_W = 144;

   typedef struct packed {
      logic [PGM_ADDR_W-1:0] addr;
      logic [PGM_DATA_W-1:0] data;
   } pgm_wr_entry_t;

   typedef enum logic [1:0] {
      GRANT_IDLE,
      GRANT_WRITE,
      GRANT_READ
   } pgm_grant_e;

   typedef enum logic {
      RET_IDLE,
      RET_PEND
   } pgm_ret_e;

endpackage

// File: rtl/pgm_wfifo.sv
// pgm_wfifo
// Posted-write FIFO for the program RAM. Besides the usual head/count view it
// exposes every slot's valid bit and address so the arbiter can look for
// read-after-write hazards against all pending writes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_entry  : enqueue request (ignored when full unless popping)
//   pop               : dequeue the head (ignored when empty)
//   head_entry        : oldest pending write
//   count, count_nxt  : current and next-cycle occupancy
//   full, empty       : occupancy flags
//   entry_valid       : per-slot valid bits
//   entry_addr        : per-slot write addresses
module pgm_wfifo
   import pgm_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   push,
   input  pgm_wr_entry_t                          push_entry,
   input  logic                                   pop,
   output pgm_wr_entry_t                          head_entry,
   output logic [$clog2(DEPTH):0]                 count,
   output logic [$clog2(DEPTH):0]                 count_nxt,
   output logic                                   full,
   output logic                                   empty,
   output logic [DEPTH-1:0]                       entry_valid,
   output logic [DEPTH-1:0][PGM_ADDR_W-1:0]       entry_addr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   pgm_wr_entry_t    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept
   // a push while it is being drained.
   always_comb begin
      empty     = (count == '0);
      full      = (count == CNT_W'(DEPTH));
      pop_ok    = pop && !empty;
      push_ok   = push && (!full || pop_ok);
      count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   // Pointers, occupancy and slot valid bits. When a full FIFO pops and
   // pushes the same slot, the set below overrides the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         count <= count_nxt;
         if (pop_ok) begin
            rd_ptr              <= rd_ptr + 1'b1;
            entry_valid[rd_ptr] <= 1'b0;
         end
         if (push_ok) begin
            wr_ptr              <= wr_ptr + 1'b1;
            entry_valid[wr_ptr] <= 1'b1;
         end
      end
   end

   // Storage is not reset; stale slots are masked by entry_valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Flatten slot addresses for the hazard compare and present the head.
   always_comb begin
      head_entry = mem[rd_ptr];
      for (int i = 0; i < DEPTH; i++) begin
         entry_addr[i] = mem[i].addr;
      end
   end

endmodule

// File: rtl/pgm_ram_arb.sv
// pgm_ram_arb
// Arbiter/sequencer for the single-port program RAM shared by the pgm_wr
// write path and the pgm_rd read path. Writes are posted into pgm_wfifo;
// reads normally win but yield on an address hazard, FIFO urgency or after
// a bounded burst of reads while writes wait.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data  : write request from pgm_wr (no backpressure)
//   wr_alf                   : FIFO almost full, upstream should hold off
//   wr_drop, wr_drop_cnt     : dropped-write pulse and saturating count
//   rd_req, rd_addr          : read request, held until rd_ack
//   rd_ack                   : read issued to the RAM this cycle
//   rd_data, rd_data_valid   : read return, one cycle after rd_ack
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata : RAM macro port
module pgm_ram_arb
   import pgm_pkg::*;
#(
   parameter int ADDR_W       = PGM_ADDR_W,
   parameter int DATA_W       = PGM_DATA_W,
   parameter int WFIFO_DEPTH  = 4,
   parameter int URGENT_LVL   = 3,
   parameter int MAX_RD_BURST = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_alf,
   output logic              wr_drop,
   output logic [15:0]       wr_drop_cnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CNT_W    = $clog2(WFIFO_DEPTH) + 1;
   localparam int STREAK_W = $clog2(MAX_RD_BURST + 1);

   pgm_wr_entry_t                              push_entry;
   pgm_wr_entry_t                              head_entry;
   logic [CNT_W-1:0]                           count;
   logic [CNT_W-1:0]                           count_nxt;
   logic                                       full;
   logic                                       empty;
   logic [WFIFO_DEPTH-1:0]                     entry_valid;
   logic [WFIFO_DEPTH-1:0][PGM_ADDR_W-1:0]     entry_addr;
   logic                                       fifo_push;
   logic                                       fifo_pop;
   logic                                       drop;
   logic                                       rd_hazard;
   logic                                       urgent;
   logic                                       starved;
   logic [STREAK_W-1:0]                        rd_streak;
   logic [DATA_W-1:0]                          rd_hold;
   pgm_grant_e                                 grant;
   pgm_ret_e                                   ret_state;
   pgm_ret_e                                   ret_state_nxt;

   assign push_entry = '{addr: wr_addr, data: wr_data};
   assign fifo_push  = wr_en && !rst;
   assign fifo_pop   = (grant == GRANT_WRITE);
   assign drop       = fifo_push && full && !fifo_pop;

   pgm_wfifo #(
      .DEPTH (WFIFO_DEPTH)
   ) u_wfifo (
      .clk         (clk),
      .rst         (rst),
      .push        (fifo_push),
      .push_entry  (push_entry),
      .pop         (fifo_pop),
      .head_entry  (head_entry),
      .count       (count),
      .count_nxt   (count_nxt),
      .full        (full),
      .empty       (empty),
      .entry_valid (entry_valid),
      .entry_addr  (entry_addr)
   );

   // The read is hazardous if any pending write targets its address. A write
   // arriving this cycle counts too: it is not visible in the FIFO yet, and
   // issuing the read now would return data older than that write.
   always_comb begin
      rd_hazard = wr_en && (wr_addr == rd_addr);
      for (int i = 0; i < WFIFO_DEPTH; i++) begin
         if (entry_valid[i] && (entry_addr[i] == rd_addr)) begin
            rd_hazard = 1'b1;
         end
      end
      urgent  = (32'(count) >= URGENT_LVL);
      starved = (32'(rd_streak) >= MAX_RD_BURST);
   end

   // Grant decision and RAM port drive. Writes take the port when there is
   // no read, or when the read must yield; a hazardous read with nothing to
   // drain leaves the port idle for a cycle.
   always_comb begin
      grant     = GRANT_IDLE;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = rd_addr;
      ram_wdata = '0;
      rd_ack    = 1'b0;
      if (!rst) begin
         if (!empty && (!rd_req || rd_hazard || urgent || starved)) begin
            grant = GRANT_WRITE;
         end else if (rd_req && !rd_hazard) begin
            grant = GRANT_READ;
         end
      end
      case (grant)
         GRANT_WRITE: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = head_entry.addr;
            ram_wdata = head_entry.data;
         end
         GRANT_READ: begin
            ram_en = 1'b1;
            rd_ack = 1'b1;
         end
         default: ;
      endcase
   end

   // Read-return tracking: a grant now means RAM data arrives next cycle.
   always_comb begin
      ret_state_nxt = RET_IDLE;
      if (grant == GRANT_READ) begin
         ret_state_nxt = RET_PEND;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ret_state <= RET_IDLE;
      end else begin
         ret_state <= ret_state_nxt;
      end
   end

   // Gating with rst drops a return that was in flight when reset arrived.
   // rd_data passes the RAM word straight through in the valid cycle and
   // otherwise shows the last returned word.
   assign rd_data_valid = (ret_state == RET_PEND) && !rst;
   assign rd_data       = rd_data_valid ? ram_rdata : rd_hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_hold <= '0;
      end else if (rd_data_valid) begin
         rd_hold <= ram_rdata;
      end
   end

   // Consecutive reads granted while writes wait; any write grant or an
   // empty FIFO restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_streak <= '0;
      end else if (grant == GRANT_WRITE || empty) begin
         rd_streak <= '0;
      end else if (grant == GRANT_READ && 32'(rd_streak) < MAX_RD_BURST) begin
         rd_streak <= rd_streak + 1'b1;
      end
   end

   // Upstream flow-control flags and dropped-write accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_alf      <= 1'b0;
         wr_drop     <= 1'b0;
         wr_drop_cnt <= '0;
      end else begin
         wr_alf  <= (32'(count_nxt) >= WFIFO_DEPTH - 1);
         wr_drop <= drop;
         if (drop && wr_drop_cnt != 16'hFFFF) begin
            wr_drop_cnt <= wr_drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pgm_ram_arb.sv
// tb_pgm_ram_arb
// Two arbiter instances run side by side: the default configuration, and one
// with urgency disabled and a longer read burst so the FIFO can actually fill
// and drop writes. Each instance has its own RAM model, queue-based reference
// model, read scoreboard and stimulus thread.
module tb_pgm_ram_arb;

   typedef struct {
      logic [6:0]   a;
      logic [143:0] d;
   } pend_t;

   typedef struct {
      logic [143:0] d;
      int           cyc;
   } exp_t;

   logic clk;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int inst,
                              input logic [143:0] act, input logic [143:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL cfg%0d %s: got %0h expected %0h", inst, name, act, exp);
      end
   endtask

   function automatic logic [143:0] randData();
      logic [143:0] d = '0;
      for (int i = 0; i < 5; i++) d = (d << 32) | 144'($urandom());
      return d;
   endfunction

   function automatic int phaseLen(input int p);
      case (p)
         0:       return 3;
         7:       return 800;
         8:       return 16;
         default: return 24;
      endcase
   endfunction

   // Per-cycle input choice. Phases: 0 reset, 1 single write/read,
   // 2 same-cycle hazard, 3 starvation, 4 urgency, 5 overflow burst,
   // 6 reset mid-operation, 7 random, 8 idle drain. A read request that has
   // not been acknowledged is always held with its address.
   task automatic applyStimulus(input int phase, input int c, input bit ack_seen,
                                input logic cur_req, input logic [6:0] cur_addr,
                                output logic rst_o, output logic wr_en_o,
                                output logic [6:0] wr_addr_o, output logic [143:0] wr_data_o,
                                output logic rd_req_o, output logic [6:0] rd_addr_o);
      bit         want = 0;
      logic [6:0] ra   = '0;
      rst_o     = 1'b0;
      wr_en_o   = 1'b0;
      wr_addr_o = '0;
      wr_data_o = '0;
      case (phase)
         0: rst_o = 1'b1;
         1: begin
            if (c == 0) begin wr_en_o = 1; wr_addr_o = 7'h05; wr_data_o = 144'hA5; end
            want = (c == 3); ra = 7'h05;
         end
         2: begin
            if (c == 0) begin wr_en_o = 1; wr_addr_o = 7'h10; wr_data_o = 144'h1; end
            want = (c == 0); ra = 7'h10;
         end
         3: begin
            if (c == 0) begin wr_en_o = 1; wr_addr_o = 7'h40; wr_data_o = randData(); end
            want = (c >= 1 && c <= 14); ra = 7'h20 + 7'(c);
         end
         4: begin
            if (c < 3) begin wr_en_o = 1; wr_addr_o = 7'h70 + 7'(c); wr_data_o = randData(); end
            want = (c < 14); ra = 7'h30 + 7'(c);
         end
         5: begin
            if (c < 6) begin wr_en_o = 1; wr_addr_o = 7'h78 + 7'(c); wr_data_o = randData(); end
            want = (c < 16); ra = 7'h50 + 7'(c);
         end
         6: begin
            if (c < 2) begin wr_en_o = 1; wr_addr_o = 7'h68 + 7'(c); wr_data_o = randData(); end
            want = (c <= 2); ra = 7'h60 + 7'(c);
            rst_o = (c == 3 || c == 4);
         end
         7: begin
            rst_o = ($urandom_range(299, 0) == 0);
            if ($urandom_range(1, 0) == 1) begin
               wr_en_o = 1; wr_addr_o = 7'($urandom_range(7, 0)); wr_data_o = randData();
            end
            want = ($urandom_range(2, 0) != 0); ra = 7'($urandom_range(7, 0));
         end
         default: ;
      endcase
      if (cur_req && !ack_seen) begin
         rd_req_o  = 1'b1;
         rd_addr_o = cur_addr;
      end else begin
         rd_req_o  = want;
         rd_addr_o = want ? ra : cur_addr;
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int URG   = (g == 0) ? 3 : 5;
      localparam int BURST = (g == 0) ? 8 : 12;
      localparam int DEPTH = 4;

      logic         rst;
      logic         wr_en;
      logic [6:0]   wr_addr;
      logic [143:0] wr_data;
      logic         wr_alf;
      logic         wr_drop;
      logic [15:0]  wr_drop_cnt;
      logic         rd_req;
      logic [6:0]   rd_addr;
      logic         rd_ack;
      logic [143:0] rd_data;
      logic         rd_data_valid;
      logic         ram_en;
      logic         ram_we;
      logic [6:0]   ram_addr;
      logic [143:0] ram_wdata;
      logic [143:0] ram_rdata;
      bit           done = 0;

      bit [143:0]   mem    [128];
      bit [143:0]   shadow [128];
      pend_t        pend   [$];
      exp_t         exp_q  [$];

      pgm_ram_arb #(
         .ADDR_W       (7),
         .DATA_W       (144),
         .WFIFO_DEPTH  (DEPTH),
         .URGENT_LVL   (URG),
         .MAX_RD_BURST (BURST)
      ) dut (
         .clk           (clk),
         .rst           (rst),
         .wr_en         (wr_en),
         .wr_addr       (wr_addr),
         .wr_data       (wr_data),
         .wr_alf        (wr_alf),
         .wr_drop       (wr_drop),
         .wr_drop_cnt   (wr_drop_cnt),
         .rd_req        (rd_req),
         .rd_addr       (rd_addr),
         .rd_ack        (rd_ack),
         .rd_data       (rd_data),
         .rd_data_valid (rd_data_valid),
         .ram_en        (ram_en),
         .ram_we        (ram_we),
         .ram_addr      (ram_addr),
         .ram_wdata     (ram_wdata),
         .ram_rdata     (ram_rdata)
      );

      // Single-port RAM macro with one-cycle read latency.
      always @(posedge clk) begin
         if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
         end
      end

      // Reference model: pending writes as a queue, grant chosen from the
      // arbitration rules, read expectations pushed to the scoreboard.
      always @(negedge clk) begin
         bit   w, hz, wsel, rsel;
         int   streak_v;
         static int   streak  = 0;
         static int   drops   = 0;
         static bit   exp_alf = 0;
         static bit   exp_drop = 0;
         if (rst) begin
            checkOutput("ram_en_in_reset", g, 144'(ram_en), 144'(1'b0));
            checkOutput("rd_ack_in_reset", g, 144'(rd_ack), 144'(1'b0));
            checkOutput("rd_valid_in_reset", g, 144'(rd_data_valid), 144'(1'b0));
            pend.delete();
            exp_q.delete();
            streak = 0; drops = 0; exp_alf = 0; exp_drop = 0;
         end else begin
            checkOutput("wr_alf", g, 144'(wr_alf), 144'(exp_alf));
            checkOutput("wr_drop", g, 144'(wr_drop), 144'(exp_drop));
            checkOutput("wr_drop_cnt", g, 144'(wr_drop_cnt), 144'(drops));
            w  = (pend.size() != 0);
            hz = wr_en && (wr_addr == rd_addr);
            foreach (pend[i]) if (pend[i].a == rd_addr) hz = 1;
            wsel = w && (!rd_req || hz || pend.size() >= URG || streak >= BURST);
            rsel = !wsel && rd_req && !hz;
            checkOutput("ram_en", g, 144'(ram_en), 144'(wsel || rsel));
            checkOutput("rd_ack", g, 144'(rd_ack), 144'(rsel));
            if (wsel || rsel) checkOutput("ram_we", g, 144'(ram_we), 144'(wsel));
            if (wsel) begin
               checkOutput("ram_wr_addr", g, 144'(ram_addr), 144'(pend[0].a));
               checkOutput("ram_wdata", g, ram_wdata, pend[0].d);
            end
            if (rsel) checkOutput("ram_rd_addr", g, 144'(ram_addr), 144'(rd_addr));
            streak_v = streak;
            if (wsel || !w) streak_v = 0;
            else if (rsel && streak_v < BURST) streak_v++;
            streak = streak_v;
            if (wsel) begin
               shadow[pend[0].a] = pend[0].d;
               void'(pend.pop_front());
            end
            if (rsel) exp_q.push_back('{d: shadow[rd_addr], cyc: cyc});
            exp_drop = 0;
            if (wr_en) begin
               if (pend.size() < DEPTH) pend.push_back('{a: wr_addr, d: wr_data});
               else begin
                  exp_drop = 1;
                  if (drops < 16'hFFFF) drops++;
               end
            end
            exp_alf = (pend.size() >= DEPTH - 1);
         end
      end

      // Scoreboard monitor: every valid return must match the oldest
      // expectation, exactly one cycle after its grant; rd_data holds otherwise.
      always @(negedge clk) begin
         static logic [143:0] last_data = '0;
         exp_t e;
         if (rst) begin
            last_data = '0;
         end else if (rd_data_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_rd_valid", g, 144'(1'b1), 144'(1'b0));
            end else begin
               e = exp_q.pop_front();
               checkOutput("rd_data", g, rd_data, e.d);
               checkOutput("rd_latency", g, 144'(cyc), 144'(e.cyc + 1));
            end
            last_data = rd_data;
         end else begin
            checkOutput("rd_data_hold", g, rd_data, last_data);
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
               checkOutput("missing_rd_valid", g, 144'(1'b0), 144'(1'b1));
               void'(exp_q.pop_front());
            end
         end
      end

      // Stimulus thread: inputs change 1 time unit after the rising edge;
      // rd_ack is sampled on the falling edge to release held requests.
      initial begin
         bit ack_seen = 0;
         rd_req  = 1'b0;
         rd_addr = '0;
         for (int p = 0; p <= 8; p++) begin
            for (int c = 0; c < phaseLen(p); c++) begin
               applyStimulus(p, c, ack_seen, rd_req, rd_addr,
                             rst, wr_en, wr_addr, wr_data, rd_req, rd_addr);
               @(negedge clk);
               ack_seen = rd_ack;
               @(posedge clk);
               #1;
            end
         end
         done = 1;
      end
   end

   initial begin
      for (int i = 0; i < 20000 && !(cfg[0].done && cfg[1].done); i++) @(posedge clk);
      if (!(cfg[0].done && cfg[1].done)) begin
         total++;
         bad++;
         $display("[TB] FAIL timeout: stimulus did not complete");
      end
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
